// File: rtl/pre_decode_stage_pkg.sv
// pd_pkg: opcode constants, format enum and per-lane decoded record for pre_decode_stage.
// The illegal-encoding field exists only when PRE_DECODE_ILLEGAL_DETECT_EN is defined.
package pd_pkg;

  localparam int PD_XLEN = 32;

  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;

  typedef enum logic [2:0] {
    PD_FMT_R   = 3'd0,
    PD_FMT_I   = 3'd1,
    PD_FMT_S   = 3'd2,
    PD_FMT_B   = 3'd3,
    PD_FMT_U   = 3'd4,
    PD_FMT_J   = 3'd5,
    PD_FMT_UNK = 3'd7
  } pd_fmt_e;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    pd_fmt_e            fmt;
    logic [PD_XLEN-1:0] imm;
`ifdef PRE_DECODE_ILLEGAL_DETECT_EN
    logic               illegal;
`endif
  } pd_lane_t;

endpackage

// File: rtl/pre_decode_stage_if.sv
// Fetch-side and decode-side bundle of pre_decode_stage, flush included.
// slave = the stage itself, master = the surrounding fetch/decode logic.
interface pre_decode_stage_if #(
  parameter int LANES = 1
);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*32-1:0] in_instr;
  logic [LANES-1:0]   in_lane_mask;
  logic               out_valid;
  logic               out_ready;
  logic [LANES-1:0]   out_lane_mask;
  logic [LANES*7-1:0] out_opcode;
  logic [LANES*3-1:0] out_funct3;
  logic [LANES*7-1:0] out_funct7;
  logic [LANES*5-1:0] out_rs1;
  logic [LANES*5-1:0] out_rs2;
  logic [LANES*5-1:0] out_rd;
  logic [LANES*3-1:0] out_fmt;
  logic [LANES*32-1:0] out_imm;
  logic [LANES-1:0]   out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_lane_mask, out_ready,
    output in_ready, out_valid, out_lane_mask, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_fmt, out_imm, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_lane_mask, out_ready,
    input  in_ready, out_valid, out_lane_mask, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_fmt, out_imm, out_illegal
  );

endinterface

// File: rtl/pre_decode_stage_lane_extract.sv
// pd_lane_extract: combinational split of one RV32I instruction into fields,
// format class and sign-extended immediate. Illegal flag under PRE_DECODE_ILLEGAL_DETECT_EN.
module pd_lane_extract
  import pd_pkg::*;
(
  input  logic [31:0] instr,
  output pd_lane_t    lane
);

  // Field extraction, opcode classification and immediate assembly
  always_comb begin
    lane        = '0;
    lane.opcode = instr[6:0];
    lane.rd     = instr[11:7];
    lane.funct3 = instr[14:12];
    lane.rs1    = instr[19:15];
    lane.rs2    = instr[24:20];
    lane.funct7 = instr[31:25];

    case (instr[6:0])
      OP_OP:                                              lane.fmt = PD_FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM:   lane.fmt = PD_FMT_I;
      OP_STORE:                                           lane.fmt = PD_FMT_S;
      OP_BRANCH:                                          lane.fmt = PD_FMT_B;
      OP_LUI, OP_AUIPC:                                   lane.fmt = PD_FMT_U;
      OP_JAL:                                             lane.fmt = PD_FMT_J;
      default:                                            lane.fmt = PD_FMT_UNK;
    endcase

    case (lane.fmt)
      PD_FMT_I: lane.imm = {{20{instr[31]}}, instr[31:20]};
      PD_FMT_S: lane.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      PD_FMT_B: lane.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      PD_FMT_U: lane.imm = {instr[31:12], 12'b0};
      PD_FMT_J: lane.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:  lane.imm = '0;
    endcase

`ifdef PRE_DECODE_ILLEGAL_DETECT_EN
    lane.illegal = (instr[1:0] != 2'b11) || (lane.fmt == PD_FMT_UNK);
`endif
  end

endmodule

// File: rtl/pre_decode_stage.sv
// pre_decode_stage: LANES-wide registered field splitter between fetch and decode,
// buffered in a DEPTH-entry FIFO with flush. Optional macro: PRE_DECODE_ILLEGAL_DETECT_EN.
module pre_decode_stage
  import pd_pkg::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input logic               clk,
  input logic               rst,
  pre_decode_stage_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  pd_lane_t         dec_lanes  [LANES];
  pd_lane_t         mem_q      [DEPTH][LANES];
  logic [LANES-1:0] mask_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, full, empty;

  // Wraps at DEPTH-1 so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      pd_lane_extract u_extract (
        .instr (bus.in_instr[32*g +: 32]),
        .lane  (dec_lanes[g])
      );
    end
  endgenerate

  // FIFO control: flush beats push/pop, a full FIFO never takes a beat
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    push     = bus.in_valid & ~full & ~bus.flush;
    pop      = bus.out_ready & ~empty & ~bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem_q[wr_ptr_q] <= bus.in_lane_mask;
      for (int i = 0; i < LANES; i++) begin
        mem_q[wr_ptr_q][i] <= dec_lanes[i];
      end
    end
  end

  // Head-entry presentation, forced to zero while the FIFO is empty
  always_comb begin
    bus.in_ready      = ~full;
    bus.out_valid     = ~empty;
    bus.out_lane_mask = '0;
    bus.out_opcode    = '0;
    bus.out_funct3    = '0;
    bus.out_funct7    = '0;
    bus.out_rs1       = '0;
    bus.out_rs2       = '0;
    bus.out_rd        = '0;
    bus.out_fmt       = '0;
    bus.out_imm       = '0;
    bus.out_illegal   = '0;
    if (!empty) begin
      bus.out_lane_mask = mask_mem_q[rd_ptr_q];
      for (int i = 0; i < LANES; i++) begin
        bus.out_opcode[7*i +: 7]       = mem_q[rd_ptr_q][i].opcode;
        bus.out_funct3[3*i +: 3]       = mem_q[rd_ptr_q][i].funct3;
        bus.out_funct7[7*i +: 7]       = mem_q[rd_ptr_q][i].funct7;
        bus.out_rs1[5*i +: 5]          = mem_q[rd_ptr_q][i].rs1;
        bus.out_rs2[5*i +: 5]          = mem_q[rd_ptr_q][i].rs2;
        bus.out_rd[5*i +: 5]           = mem_q[rd_ptr_q][i].rd;
        bus.out_fmt[3*i +: 3]          = mem_q[rd_ptr_q][i].fmt;
        bus.out_imm[XLEN*i +: XLEN]    = mem_q[rd_ptr_q][i].imm;
`ifdef PRE_DECODE_ILLEGAL_DETECT_EN
        bus.out_illegal[i]             = mem_q[rd_ptr_q][i].illegal;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pre_decode_stage.sv
// Randomized bench for pre_decode_stage with a queue model and per-cycle compare.
// Honours PRE_DECODE_ILLEGAL_DETECT_EN the same way as the design.
module tb_pre_decode_stage;

  localparam int LANES = 2;
  localparam int DEPTH = 3;
  localparam int W     = LANES * 32;

  logic clk = 1'b0;
  logic rst;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pre_decode_stage_if #(.LANES(LANES)) bus ();

  pre_decode_stage #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [LANES-1:0] mask;
    logic [W-1:0]     instr;
  } beat_t;

  beat_t q[$];

  function automatic logic [2:0] m_fmt(input logic [31:0] x);
    case (x[6:0])
      7'b0110011: return 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: return 3'd1;
      7'b0100011: return 3'd2;
      7'b1100011: return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      7'b1101111: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] x);
    case (m_fmt(x))
      3'd1: return {{20{x[31]}}, x[31:20]};
      3'd2: return {{20{x[31]}}, x[31:25], x[11:7]};
      3'd3: return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      3'd4: return {x[31:12], 12'b0};
      3'd5: return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_ill(input logic [31:0] x);
`ifdef PRE_DECODE_ILLEGAL_DETECT_EN
    return (x[1:0] != 2'b11) || (m_fmt(x) == 3'd7);
`else
    return 1'b0 & x[0];
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [LANES-1:0]   e_mask = '0;
    logic [LANES*7-1:0] e_op = '0, e_f7 = '0;
    logic [LANES*3-1:0] e_f3 = '0, e_fmt = '0;
    logic [LANES*5-1:0] e_rs1 = '0, e_rs2 = '0, e_rd = '0;
    logic [W-1:0]       e_imm = '0;
    logic [LANES-1:0]   e_ill = '0;
    logic [31:0]        x;
    if (q.size() > 0) begin
      e_mask = q[0].mask;
      for (int i = 0; i < LANES; i++) begin
        x = q[0].instr[32*i +: 32];
        e_op[7*i +: 7]   = x[6:0];
        e_rd[5*i +: 5]   = x[11:7];
        e_f3[3*i +: 3]   = x[14:12];
        e_rs1[5*i +: 5]  = x[19:15];
        e_rs2[5*i +: 5]  = x[24:20];
        e_f7[7*i +: 7]   = x[31:25];
        e_fmt[3*i +: 3]  = m_fmt(x);
        e_imm[32*i +: 32] = m_imm(x);
        e_ill[i]         = m_ill(x);
      end
    end
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
    chk("out_lane_mask", 64'(bus.out_lane_mask), 64'(e_mask));
    chk("out_opcode", 64'(bus.out_opcode), 64'(e_op));
    chk("out_funct3", 64'(bus.out_funct3), 64'(e_f3));
    chk("out_funct7", 64'(bus.out_funct7), 64'(e_f7));
    chk("out_rs1", 64'(bus.out_rs1), 64'(e_rs1));
    chk("out_rs2", 64'(bus.out_rs2), 64'(e_rs2));
    chk("out_rd", 64'(bus.out_rd), 64'(e_rd));
    chk("out_fmt", 64'(bus.out_fmt), 64'(e_fmt));
    chk("out_imm", 64'(bus.out_imm), 64'(e_imm));
    chk("out_illegal", 64'(bus.out_illegal), 64'(e_ill));
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) compare_outputs();
  end

  // Drive one cycle of inputs, then advance the model across the clock edge.
  task automatic drive(input logic v, input logic [W-1:0] ins, input logic [LANES-1:0] mask,
                       input logic rdy, input logic fl);
    bit can_push;
    bus.in_valid     = v;
    bus.in_instr     = ins;
    bus.in_lane_mask = mask;
    bus.out_ready    = rdy;
    bus.flush        = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      can_push = (q.size() < DEPTH);
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (v && can_push) q.push_back('{mask: mask, instr: ins});
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                              7'b0001111, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                              7'b1101111};
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] b;
    for (int i = 0; i < LANES; i++) b[32*i +: 32] = rand_instr();
    return b;
  endfunction

  logic [W-1:0] held;

  initial begin
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_instr     = '0;
    bus.in_lane_mask = '0;
    bus.out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_imm", 64'(bus.out_imm), 64'd0);
    drive(0, '0, '0, 0, 0);
    chk("idle out_valid", 64'(bus.out_valid), 64'd0);

    // addi x1,x2,-1 in lane 0
    drive(1, {rand_instr(), 32'hFFF10093}, 2'b01, 1, 0);
    chk("addi valid", 64'(bus.out_valid), 64'd1);
    chk("addi opcode", 64'(bus.out_opcode[6:0]), 64'h13);
    chk("addi rd", 64'(bus.out_rd[4:0]), 64'd1);
    chk("addi rs1", 64'(bus.out_rs1[4:0]), 64'd2);
    chk("addi funct3", 64'(bus.out_funct3[2:0]), 64'd0);
    chk("addi fmt", 64'(bus.out_fmt[2:0]), 64'd1);
    chk("addi imm", 64'(bus.out_imm[31:0]), 64'hFFFFFFFF);
    chk("addi mask", 64'(bus.out_lane_mask), 64'd1);
    drive(0, '0, '0, 1, 0);

    // sw x5,8(x6), then lui x5,0x12345 pushed while sw is popped
    drive(1, {32'h123452B7, 32'h00532423}, 2'b11, 1, 0);
    chk("sw fmt", 64'(bus.out_fmt[2:0]), 64'd2);
    chk("sw rs1", 64'(bus.out_rs1[4:0]), 64'd6);
    chk("sw rs2", 64'(bus.out_rs2[4:0]), 64'd5);
    chk("sw funct3", 64'(bus.out_funct3[2:0]), 64'd2);
    chk("sw imm", 64'(bus.out_imm[31:0]), 64'h8);
    chk("lane1 lui fmt", 64'(bus.out_fmt[5:3]), 64'd4);
    drive(1, {32'h00532423, 32'h123452B7}, 2'b01, 1, 0);
    chk("lui fmt", 64'(bus.out_fmt[2:0]), 64'd4);
    chk("lui rd", 64'(bus.out_rd[4:0]), 64'd5);
    chk("lui imm", 64'(bus.out_imm[31:0]), 64'h12345000);
    drive(0, '0, '0, 1, 0);

    // Fill with out_ready low, then hold a beat while full and drain
    for (int k = 0; k < DEPTH; k++) drive(1, rand_beat(), 2'b11, 0, 0);
    chk("full in_ready", 64'(bus.in_ready), 64'd0);
    held = rand_beat();
    drive(1, held, 2'b10, 0, 0);
    chk("still full", 64'(bus.in_ready), 64'd0);
    drive(1, held, 2'b10, 1, 0);
    drive(1, held, 2'b10, 1, 0);
    for (int k = 0; k < DEPTH + 2; k++) drive(0, '0, '0, 1, 0);
    chk("drained", 64'(bus.out_valid), 64'd0);

    // Flush with two entries and a beat offered in the same cycle
    drive(1, rand_beat(), 2'b11, 0, 0);
    drive(1, rand_beat(), 2'b11, 0, 0);
    drive(1, {32'hFFFFFFFF, 32'h0000006F}, 2'b11, 0, 1);
    chk("flush out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush in_ready", 64'(bus.in_ready), 64'd1);
    drive(0, '0, '0, 1, 0);
    chk("flush beat dropped", 64'(bus.out_valid), 64'd0);

    // Illegal encodings
    drive(1, {32'h0000007F, 32'h00000000}, 2'b11, 0, 0);
`ifdef PRE_DECODE_ILLEGAL_DETECT_EN
    chk("illegal bits", 64'(bus.out_illegal), 64'd3);
`else
    chk("illegal bits", 64'(bus.out_illegal), 64'd0);
`endif
    chk("unk fmt lane1", 64'(bus.out_fmt[5:3]), 64'd7);
    drive(0, '0, '0, 1, 0);

    // Reset mid-operation
    drive(1, rand_beat(), 2'b11, 0, 0);
    drive(1, rand_beat(), 2'b01, 0, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("async rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("async rst out_imm", 64'(bus.out_imm), 64'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 7, rand_beat(), LANES'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    end
    for (int k = 0; k < DEPTH + 1; k++) drive(0, '0, '0, 1, 0);
    @(negedge clk);
    #1 chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
